// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned NPORTS = 2;
  // Widest address the request struct carries; narrower AW values are zero-extended into it.
  localparam int unsigned MaxAw  = 32;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic             we;
    logic [3:0]       be;
    logic [MaxAw-1:0] addr;
    logic [31:0]      wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the port that did not win last time is chosen.
module rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       grant_o
);

  // Tie goes to the port that was not granted last; otherwise follow whichever is valid.
  always_comb begin
    if (&valid_i) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = valid_i[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port data memory between the core LSU (port 0) and a DMA/debug
// loader (port 1). Round-robin on conflict, optional burst lock with a hold limit,
// and a one-cycle registered read response per port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 16,
  parameter int unsigned AW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [3:0]    req0_be,
  input  logic [AW-1:0] req0_addr,
  input  logic [31:0]   req0_wdata,
  input  logic          req0_lock,
  output logic          resp0_valid,
  output logic [31:0]   resp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [3:0]    req1_be,
  input  logic [AW-1:0] req1_addr,
  input  logic [31:0]   req1_wdata,
  input  logic          req1_lock,
  output logic          resp1_valid,
  output logic [31:0]   resp1_rdata,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  localparam int unsigned CntW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_MAX - 1);

  arb_state_t      state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic            resp0_valid_q, resp0_valid_d;
  logic            resp1_valid_q, resp1_valid_d;
  logic [31:0]     resp0_rdata_q, resp0_rdata_d;
  logic [31:0]     resp1_rdata_q, resp1_rdata_d;

  logic            rr_grant;
  logic            grant;
  logic            xfer;
  logic            sel_lock;
  mem_req_t        req0_s, req1_s, sel_req;

  rr_pick2 u_rr_pick2 (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (rr_grant)
  );

  // Grant selection: round-robin while arbitrating, pinned to the owner while locked.
  always_comb begin
    grant = rr_grant;
    unique case (state_q)
      ARB:     grant = rr_grant;
      LOCK0:   grant = 1'b0;
      LOCK1:   grant = 1'b1;
      default: grant = rr_grant;
    endcase
  end

  assign req0_ready = ~grant & req0_valid & ~reset;
  assign req1_ready =  grant & req1_valid & ~reset;
  assign xfer       = req0_ready | req1_ready;

  // Request mux toward the memory; idle cycles park on port 0 with writes disabled.
  always_comb begin
    req0_s   = '{we: req0_we, be: req0_be, addr: MaxAw'(req0_addr), wdata: req0_wdata};
    req1_s   = '{we: req1_we, be: req1_be, addr: MaxAw'(req1_addr), wdata: req1_wdata};
    sel_req  = grant ? req1_s : req0_s;
    sel_lock = grant ? req1_lock : req0_lock;
    if (xfer) begin
      mem_we = sel_req.we;
      mem_be = sel_req.be;
      mem_a  = AW'(sel_req.addr);
      mem_wd = sel_req.wdata;
    end else begin
      mem_we = 1'b0;
      mem_be = 4'b0000;
      mem_a  = AW'(req0_s.addr);
      mem_wd = req0_s.wdata;
    end
  end

  // Lock FSM, round-robin history and response capture.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    lock_cnt_d    = lock_cnt_q;
    if (xfer) begin
      last_grant_d = grant;
    end
    unique case (state_q)
      ARB: begin
        if (xfer && sel_lock) begin
          state_d    = grant ? LOCK1 : LOCK0;
          lock_cnt_d = '0;
        end
      end
      LOCK0, LOCK1: begin
        lock_cnt_d = lock_cnt_q + CntW'(1);
        // Forced release still lets a transfer in this cycle complete.
        if ((xfer && !sel_lock) || (lock_cnt_q == CntLast)) begin
          state_d      = ARB;
          last_grant_d = (state_q == LOCK1);
          lock_cnt_d   = '0;
        end
      end
      default: begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    endcase
    resp0_valid_d = req0_ready;
    resp1_valid_d = req1_ready;
    resp0_rdata_d = req0_ready ? mem_rd : resp0_rdata_q;
    resp1_rdata_d = req1_ready ? mem_rd : resp1_rdata_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ARB;
      last_grant_q  <= 1'b1;
      lock_cnt_q    <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      lock_cnt_q    <= lock_cnt_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_rdata_q <= resp0_rdata_d;
      resp1_rdata_q <= resp1_rdata_d;
    end
  end

  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_rdata = resp0_rdata_q;
  assign resp1_rdata = resp1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;

  logic          clk;
  logic          reset;
  logic          req0_valid, req0_ready, req0_we, req0_lock;
  logic [3:0]    req0_be;
  logic [AW-1:0] req0_addr;
  logic [31:0]   req0_wdata;
  logic          resp0_valid;
  logic [31:0]   resp0_rdata;
  logic          req1_valid, req1_ready, req1_we, req1_lock;
  logic [3:0]    req1_be;
  logic [AW-1:0] req1_addr;
  logic [31:0]   req1_wdata;
  logic          resp1_valid;
  logic [31:0]   resp1_rdata;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  logic [31:0]   mem [0:63];
  logic          pre_we;
  logic [5:0]    pre_idx;
  logic [31:0]   pre_data;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(
    .LOCK_MAX (4),
    .AW       (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_we     (req0_we),
    .req0_be     (req0_be),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_lock   (req0_lock),
    .resp0_valid (resp0_valid),
    .resp0_rdata (resp0_rdata),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_we     (req1_we),
    .req1_be     (req1_be),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_lock   (req1_lock),
    .resp1_valid (resp1_valid),
    .resp1_rdata (resp1_rdata),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_a       (mem_a),
    .mem_wd      (mem_wd),
    .mem_rd      (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational word read, synchronous byte-enabled write.
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_a[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  task automatic idle_inputs();
    req0_valid = 0; req0_we = 0; req0_be = 4'h0; req0_addr = '0; req0_wdata = '0;
    req0_lock = 0;
    req1_valid = 0; req1_we = 0; req1_be = 4'h0; req1_addr = '0; req1_wdata = '0;
    req1_lock = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pre_idx = idx; pre_data = data; pre_we = 1'b1;
    next_cycle();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    req0_valid = 1; req0_we = 1; req0_be = 4'hF;
    req1_valid = 1; req1_we = 1; req1_be = 4'hF;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got %b%b exp 00", req1_ready, req0_ready);
    end
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we);
    end
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_resp_valid got %b%b exp 00", resp1_valid, resp0_valid);
    end
    checks++;
    if (resp0_rdata !== 32'h0 || resp1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata got %h %h exp 0 0", resp0_rdata, resp1_rdata);
    end
    next_cycle();
  endtask

  task automatic test_single_read();
    apply_reset();
    req0_valid = 1; req0_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL t1_ready got %b%b exp 01", req1_ready, req0_ready);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b1 || resp0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL t1_resp0 got v=%b %h exp v=1 deadbeef", resp0_valid, resp0_rdata);
    end
    checks++;
    if (resp1_valid !== 1'b0) begin
      errors++; $display("FAIL t1_resp1_valid got %b exp 0", resp1_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b0) begin
      errors++; $display("FAIL t1_resp0_oneshot got %b exp 0", resp0_valid);
    end
    next_cycle();
  endtask

  task automatic test_alternate();
    logic exp0;
    apply_reset();
    req0_valid = 1; req0_addr = 32'h10;
    req1_valid = 1; req1_addr = 32'h14;
    for (int i = 0; i < 6; i++) begin
      exp0 = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (req0_ready !== exp0 || req1_ready !== !exp0) begin
        errors++;
        $display("FAIL t2_ready[%0d] got %b%b exp %b%b", i, req1_ready, req0_ready, !exp0, exp0);
      end
      if (i > 0) begin
        checks++;
        if (resp0_valid !== !exp0 || resp1_valid !== exp0) begin
          errors++;
          $display("FAIL t2_resp[%0d] got %b%b exp %b%b", i, resp1_valid, resp0_valid,
                   exp0, !exp0);
        end
        checks++;
        if (exp0 && resp1_rdata !== 32'h55555555) begin
          errors++; $display("FAIL t2_rdata1[%0d] got %h exp 55555555", i, resp1_rdata);
        end else if (!exp0 && resp0_rdata !== 32'hDEADBEEF) begin
          errors++; $display("FAIL t2_rdata0[%0d] got %h exp deadbeef", i, resp0_rdata);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_lock_burst();
    logic lock_seq [0:2];
    lock_seq[0] = 1'b1; lock_seq[1] = 1'b1; lock_seq[2] = 1'b0;
    apply_reset();
    // Port 0 takes one transfer alone so the upcoming tie favours port 1.
    req0_valid = 1; req0_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL t3_pre_ready0 got %b exp 1", req0_ready);
    end
    next_cycle();
    req1_valid = 1; req1_we = 1; req1_addr = 32'h8; req1_wdata = 32'h12345678;
    req1_be = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      req1_lock = lock_seq[i];
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b1 || mem_we !== 1'b1) begin
        errors++;
        $display("FAIL t3_burst[%0d] got r0=%b r1=%b we=%b exp 0 1 1", i, req0_ready,
                 req1_ready, mem_we);
      end
      if (i == 1) begin
        checks++;
        if (resp1_valid !== 1'b1 || resp1_rdata !== 32'hAAAABBBB) begin
          errors++;
          $display("FAIL t3_resp1 got v=%b %h exp v=1 aaaabbbb", resp1_valid, resp1_rdata);
        end
      end
      next_cycle();
    end
    req1_valid = 0; req1_we = 0; req1_lock = 0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL t3_after_ready0 got %b exp 1", req0_ready);
    end
    checks++;
    if (mem[2] !== 32'hAAAA5678) begin
      errors++; $display("FAIL t3_word2 got %h exp aaaa5678", mem[2]);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_lock_forced();
    apply_reset();
    req0_valid = 1; req0_addr = 32'h10;
    next_cycle();
    // One entry transfer plus LOCK_MAX=4 locked cycles before the forced release.
    req1_valid = 1; req1_addr = 32'h14; req1_lock = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
        errors++;
        $display("FAIL t4_locked[%0d] got r0=%b r1=%b exp 0 1", i, req0_ready, req1_ready);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL t4_release got r0=%b r1=%b exp 1 0", req0_ready, req1_ready);
    end
    checks++;
    if (resp1_valid !== 1'b1 || resp1_rdata !== 32'h55555555) begin
      errors++;
      $display("FAIL t4_last_resp1 got v=%b %h exp v=1 55555555", resp1_valid, resp1_rdata);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_in_lock();
    apply_reset();
    req1_valid = 1; req1_addr = 32'h14; req1_lock = 1;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL t5_enter got %b exp 1", req1_ready);
    end
    next_cycle();
    reset = 1'b1;
    req1_we = 1; req1_be = 4'hF; req1_wdata = 32'h0;
    req0_valid = 1; req0_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL t5_rst_cycle got r0=%b r1=%b we=%b exp 0 0 0", req0_ready, req1_ready,
               mem_we);
    end
    checks++;
    if (mem_be !== 4'h0 || mem_a !== 32'h10) begin
      errors++; $display("FAIL t5_idle_drive got be=%h a=%h exp 0 10", mem_be, mem_a);
    end
    checks++;
    if (resp1_valid !== 1'b1) begin
      errors++; $display("FAIL t5_pending got %b exp 1", resp1_valid);
    end
    next_cycle();
    reset = 1'b0;
    req1_we = 0; req1_lock = 0;
    @(negedge clk);
    checks++;
    if (resp1_valid !== 1'b0 || resp1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL t5_resp1_cleared got v=%b %h exp v=0 0", resp1_valid, resp1_rdata);
    end
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL t5_tie got r0=%b r1=%b exp 1 0", req0_ready, req1_ready);
    end
    checks++;
    if (mem[5] !== 32'h55555555) begin
      errors++; $display("FAIL t5_no_write got %h exp 55555555", mem[5]);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_write_then_read();
    apply_reset();
    req0_valid = 1; req0_we = 1; req0_be = 4'hF; req0_addr = 32'h20;
    req0_wdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_wd !== 32'hCAFEF00D || mem_a !== 32'h20) begin
      errors++;
      $display("FAIL t6_wr_drive got we=%b wd=%h a=%h exp 1 cafef00d 20", mem_we, mem_wd,
               mem_a);
    end
    next_cycle();
    req0_we = 0; req0_be = 4'h0;
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b1 || resp0_rdata !== 32'h11112222) begin
      errors++;
      $display("FAIL t6_wr_resp got v=%b %h exp v=1 11112222", resp0_valid, resp0_rdata);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b1 || resp0_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL t6_rd_resp got v=%b %h exp v=1 cafef00d", resp0_valid, resp0_rdata);
    end
    next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    idle_inputs();
    preload(6'd2, 32'hAAAABBBB);
    preload(6'd4, 32'hDEADBEEF);
    preload(6'd5, 32'h55555555);
    preload(6'd8, 32'h11112222);
    test_reset();
    test_single_read();
    test_alternate();
    test_lock_burst();
    test_lock_forced();
    test_reset_in_lock();
    test_write_then_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
